// File: rtl/const_bank_ctrl.sv
// const_bank_ctrl: double-buffered constant register file for the PE array.
//   The host writes a shadow bank while the PE array reads a stable active bank.
//   A commit swaps the banks at a PE-idle boundary, then copies the new active
//   bank back into the shadow so later partial updates start from current data.
//   Optional build macro CONST_BCAST_EN: an accepted write with i_bcast=1 fills
//   every shadow entry; without it i_bcast is ignored.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_we, i_re, i_glb_adr      host write/read strobes and global address
//   i_wdata, i_bcast           host write data and broadcast qualifier
//   i_rd_active                readback source (1 = active, 0 = shadow)
//   o_wr_ready                 shadow bank accepts writes
//   o_rdata, o_rvalid          registered readback, valid one cycle after read
//   i_commit_req, i_pe_idle    commit request pulse, PE context boundary
//   o_commit_busy              commit in progress
//   o_commit_done              one-cycle pulse at commit completion
//   o_const_data               active bank, entry 0 in the LSBs
module const_bank_ctrl #(
    parameter int DATA_W = 16,
    parameter int ENTRY = 16,
    parameter int ADR_W = 4,
    parameter int GLB_ADR_W = 16,
    parameter int HEAD_W = 4,
    parameter logic [HEAD_W-1:0] HEAD_CONST = 4'h2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_we,
    input  logic                    i_re,
    input  logic [GLB_ADR_W-1:0]    i_glb_adr,
    input  logic [DATA_W-1:0]       i_wdata,
    input  logic                    i_bcast,
    input  logic                    i_rd_active,
    output logic                    o_wr_ready,
    output logic [DATA_W-1:0]       o_rdata,
    output logic                    o_rvalid,
    input  logic                    i_commit_req,
    input  logic                    i_pe_idle,
    output logic                    o_commit_busy,
    output logic                    o_commit_done,
    output logic [ENTRY*DATA_W-1:0] o_const_data
);
    typedef enum logic [2:0] {IDLE, PEND, SWAP, COPY, DONE} state_t;
    state_t state_q;
    logic bank_sel_q;
    logic [ADR_W-1:0] cnt_q;
    logic [DATA_W-1:0] bank_q [2][ENTRY];
    logic hit;
    logic wr_acc;
    logic rd_acc;
    logic [ADR_W-1:0] idx;
    logic [GLB_ADR_W-HEAD_W-ADR_W-1:0] unused_adr;
    assign hit = i_glb_adr[GLB_ADR_W-1 -: HEAD_W] == HEAD_CONST;
    assign idx = i_glb_adr[ADR_W-1:0];
    assign unused_adr = i_glb_adr[GLB_ADR_W-HEAD_W-1:ADR_W];
    assign o_wr_ready = (state_q == IDLE) || (state_q == PEND);
    assign o_commit_busy = state_q != IDLE;
    assign wr_acc = i_we & hit & o_wr_ready;
    assign rd_acc = i_re & hit;
`ifndef CONST_BCAST_EN
    logic unused_bcast;
    assign unused_bcast = i_bcast;
`endif
    for (genvar g = 0; g < ENTRY; g++) begin : g_out
        assign o_const_data[g*DATA_W +: DATA_W] = bank_q[bank_sel_q][g];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bank_sel_q <= 1'b0;
            cnt_q <= '0;
            o_commit_done <= 1'b0;
        end else begin
            o_commit_done <= 1'b0;
            case (state_q)
                IDLE: if (i_commit_req) state_q <= PEND;
                PEND: if (i_pe_idle) state_q <= SWAP;
                SWAP: begin
                    bank_sel_q <= ~bank_sel_q;
                    cnt_q <= '0;
                    state_q <= COPY;
                end
                COPY: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == ADR_W'(ENTRY - 1)) begin
                        state_q <= DONE;
                        o_commit_done <= 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    // Host writes and the copy-back never overlap: o_wr_ready is low in COPY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int e = 0; e < ENTRY; e++)
                    bank_q[b][e] <= '0;
            o_rdata <= '0;
            o_rvalid <= 1'b0;
        end else begin
            o_rvalid <= rd_acc;
            if (rd_acc) o_rdata <= bank_q[i_rd_active ? bank_sel_q : ~bank_sel_q][idx];
            if (wr_acc) begin
`ifdef CONST_BCAST_EN
                if (i_bcast)
                    for (int e = 0; e < ENTRY; e++)
                        bank_q[~bank_sel_q][e] <= i_wdata;
                else
                    bank_q[~bank_sel_q][idx] <= i_wdata;
`else
                bank_q[~bank_sel_q][idx] <= i_wdata;
`endif
            end
            if (state_q == COPY) bank_q[~bank_sel_q][cnt_q] <= bank_q[bank_sel_q][cnt_q];
        end
    end
endmodule

// File: tb/tb_const_bank_ctrl.sv
// tb_const_bank_ctrl: table-driven and sequence checks with a readback scoreboard.
module tb_const_bank_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_we = 1'b0;
    logic i_re = 1'b0;
    logic [15:0] i_glb_adr = '0;
    logic [15:0] i_wdata = '0;
    logic i_bcast = 1'b0;
    logic i_rd_active = 1'b0;
    logic o_wr_ready;
    logic [15:0] o_rdata;
    logic o_rvalid;
    logic i_commit_req = 1'b0;
    logic i_pe_idle = 1'b0;
    logic o_commit_busy;
    logic o_commit_done;
    logic [255:0] o_const_data;
    const_bank_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_we(i_we), .i_re(i_re), .i_glb_adr(i_glb_adr),
        .i_wdata(i_wdata), .i_bcast(i_bcast), .i_rd_active(i_rd_active),
        .o_wr_ready(o_wr_ready), .o_rdata(o_rdata), .o_rvalid(o_rvalid),
        .i_commit_req(i_commit_req), .i_pe_idle(i_pe_idle), .o_commit_busy(o_commit_busy),
        .o_commit_done(o_commit_done), .o_const_data(o_const_data)
    );
    always #5 clk = ~clk;
    typedef struct {
        bit we;
        bit re;
        logic [3:0] head;
        logic [3:0] idx;
        logic [15:0] wdata;
        bit act;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[$];
    logic [15:0] exp_q[$];
    logic [15:0] act_m [16];
    logic [15:0] shd_m [16];
    int n_tests = 0;
    int n_fail = 0;
    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [255:0] pk();
        logic [255:0] v;
        for (int e = 0; e < 16; e++) v[e*16 +: 16] = act_m[e];
        return v;
    endfunction
    task automatic idle_in();
        i_we = 1'b0;
        i_re = 1'b0;
        i_bcast = 1'b0;
        i_commit_req = 1'b0;
    endtask
    // One clock: the readback expected for this edge is popped from the scoreboard.
    task automatic tick();
        bit exp_rv;
        logic [15:0] e;
        exp_rv = i_re && (i_glb_adr[15:12] == 4'h2);
        @(posedge clk);
        #1;
        chk("rvalid", {255'd0, o_rvalid}, {255'd0, exp_rv});
        if (o_rvalid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rdata: got %h with no expected value queued", o_rdata);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", {240'd0, o_rdata}, {240'd0, e});
            end
        end
    endtask
    task automatic drive(bit we, bit re, logic [3:0] head, logic [3:0] idx, logic [15:0] wd, bit act, logic [15:0] exp);
        i_we = we;
        i_re = re;
        i_glb_adr = {head, 8'h00, idx};
        i_wdata = wd;
        i_rd_active = act;
        if (re && head == 4'h2) exp_q.push_back(exp);
        if (we && head == 4'h2 && o_wr_ready) shd_m[idx] = wd;
    endtask
    task automatic rd(logic [3:0] idx, bit act, logic [15:0] exp);
        drive(1'b0, 1'b1, 4'h2, idx, 16'h0, act, exp);
        tick();
        idle_in();
    endtask
    // Commit with i_pe_idle already high; cycle k counts edges after the request.
    task automatic commit_fast(string tag);
        int t_done;
        int n_done;
        t_done = -1;
        n_done = 0;
        i_pe_idle = 1'b1;
        i_commit_req = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            idle_in();
            if (k == 2) begin
                chk({tag, "_const_pre_swap"}, o_const_data, pk());
                for (int e = 0; e < 16; e++) act_m[e] = shd_m[e];
            end
            if (k == 3) chk({tag, "_const_post_swap"}, o_const_data, pk());
            if (o_commit_done) begin
                n_done++;
                if (t_done < 0) t_done = k;
            end
        end
        chk({tag, "_done_latency"}, 256'(t_done), 256'd19);
        chk({tag, "_done_count"}, 256'(n_done), 256'd1);
    endtask
    initial begin
        int t_done;
        int n_done;
        for (int e = 0; e < 16; e++) begin
            act_m[e] = '0;
            shd_m[e] = '0;
        end
        vecs.push_back('{0, 1, 4'h2, 4'd5, 16'h0000, 1, 16'h0000});
        vecs.push_back('{1, 0, 4'h2, 4'd3, 16'hABCD, 0, 16'h0000});
        vecs.push_back('{0, 1, 4'h2, 4'd3, 16'h0000, 0, 16'hABCD});
        vecs.push_back('{0, 1, 4'h2, 4'd3, 16'h0000, 1, 16'h0000});
        vecs.push_back('{1, 0, 4'h1, 4'd0, 16'h1111, 0, 16'h0000});
        vecs.push_back('{0, 1, 4'h2, 4'd0, 16'h0000, 0, 16'h0000});
        vecs.push_back('{0, 1, 4'h2, 4'd0, 16'h0000, 1, 16'h0000});
        vecs.push_back('{1, 1, 4'h2, 4'd3, 16'h1234, 0, 16'hABCD});
        vecs.push_back('{0, 1, 4'h2, 4'd3, 16'h0000, 0, 16'h1234});
        vecs.push_back('{1, 0, 4'h2, 4'd3, 16'hABCD, 0, 16'h0000});
        vecs.push_back('{1, 0, 4'h2, 4'd15, 16'hBEEF, 0, 16'h0000});
        vecs.push_back('{0, 1, 4'h2, 4'd15, 16'h0000, 0, 16'hBEEF});
        vecs.push_back('{0, 1, 4'h1, 4'd15, 16'h0000, 0, 16'h0000});
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_ready", {255'd0, o_wr_ready}, {255'd0, 1'b1});
        chk("rst_busy", {255'd0, o_commit_busy}, 256'd0);
        chk("rst_done", {255'd0, o_commit_done}, 256'd0);
        chk("rst_rvalid", {255'd0, o_rvalid}, 256'd0);
        chk("rst_rdata", {240'd0, o_rdata}, 256'd0);
        chk("rst_const", o_const_data, 256'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].re, vecs[i].head, vecs[i].idx, vecs[i].wdata, vecs[i].act, vecs[i].exp);
            tick();
            idle_in();
            chk("tbl_const", o_const_data, pk());
            chk("tbl_wr_ready", {255'd0, o_wr_ready}, {255'd0, 1'b1});
        end
        // Commit held in PEND by a busy PE array; a PEND write joins the swap.
        i_pe_idle = 1'b0;
        i_commit_req = 1'b1;
        tick();
        idle_in();
        chk("pend_busy", {255'd0, o_commit_busy}, {255'd0, 1'b1});
        for (int k = 0; k < 10; k++) begin
            if (k == 5) drive(1'b1, 1'b0, 4'h2, 4'd1, 16'h0101, 0, 16'h0);
            tick();
            idle_in();
            chk("pend_wr_ready", {255'd0, o_wr_ready}, {255'd0, 1'b1});
            chk("pend_const", o_const_data, pk());
        end
        i_pe_idle = 1'b1;
        tick();
        chk("swap_wr_ready", {255'd0, o_wr_ready}, 256'd0);
        chk("swap_const_old", o_const_data, pk());
        for (int e = 0; e < 16; e++) act_m[e] = shd_m[e];
        t_done = -1;
        n_done = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 2) begin
                chk("copy_wr_ready", {255'd0, o_wr_ready}, 256'd0);
                drive(1'b1, 1'b0, 4'h2, 4'd4, 16'h4444, 0, 16'h0);
            end
            if (k == 4) i_commit_req = 1'b1;
            tick();
            idle_in();
            if (k == 1) begin
                chk("swap_const_new", o_const_data, pk());
                chk("swap_slice3", {240'd0, o_const_data[63:48]}, {240'd0, 16'hABCD});
            end
            if (o_commit_done) begin
                n_done++;
                if (t_done < 0) t_done = k;
            end
        end
        chk("done_after_swap", 256'(t_done), 256'd17);
        chk("done_pulses", 256'(n_done), 256'd1);
        chk("idle_busy", {255'd0, o_commit_busy}, 256'd0);
        chk("idle_const", o_const_data, pk());
        rd(4'd3, 0, 16'hABCD);
        rd(4'd1, 0, 16'h0101);
        rd(4'd15, 0, 16'hBEEF);
        rd(4'd4, 0, 16'h0000);
        drive(1'b1, 1'b0, 4'h2, 4'd4, 16'h4444, 0, 16'h0);
        tick();
        idle_in();
        rd(4'd4, 0, 16'h4444);
        rd(4'd4, 1, 16'h0000);
        commit_fast("fast");
        rd(4'd4, 1, 16'h4444);
        rd(4'd0, 1, 16'h0000);
        i_bcast = 1'b1;
        drive(1'b1, 1'b0, 4'h2, 4'd9, 16'h0055, 0, 16'h0);
`ifdef CONST_BCAST_EN
        for (int e = 0; e < 16; e++) shd_m[e] = 16'h0055;
`endif
        tick();
        idle_in();
        commit_fast("bcast");
        chk("bcast_const", o_const_data, pk());
        rd(4'd9, 0, 16'h0055);
        // Reset in the middle of COPY clears both banks and the FSM.
        i_commit_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            idle_in();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_const", o_const_data, 256'd0);
        chk("arst_busy", {255'd0, o_commit_busy}, 256'd0);
        chk("arst_wr_ready", {255'd0, o_wr_ready}, {255'd0, 1'b1});
        chk("arst_done", {255'd0, o_commit_done}, 256'd0);
        for (int e = 0; e < 16; e++) begin
            act_m[e] = '0;
            shd_m[e] = '0;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(4'd3, 0, 16'h0000);
        rd(4'd9, 1, 16'h0000);
        chk("scoreboard_empty", 256'(exp_q.size()), 256'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
